rpn_calc_core: RTL

Parametrised stack-based (RPN) integer calculator core, the next generation of our calculator datapath. Holds a DEPTH-entry operand stack of WIDTH-bit values and executes push/pop/arithmetic commands over a valid/ready handshake. Single-cycle ops handle add, sub, swap, pop and clear; multiply is iterative and multi-cycle. Sits behind the top-level pin wrapper, which maps pins onto the command and result ports.

---
 rtl/calc_pkg.sv | 26 ++
 rtl/rpn_calc_core_if.sv | 25 ++
 rtl/calc_seq_mult.sv | 48 ++++
 rtl/rpn_calc_core.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// Shared types for the RPN calculator core: opcodes, error codes and FSM states.
package calc_pkg;

  typedef enum logic [2:0] {
    OP_NOP   = 3'd0,
    OP_PUSH  = 3'd1,
    OP_POP   = 3'd2,
    OP_ADD   = 3'd3,
    OP_SUB   = 3'd4,
    OP_MUL   = 3'd5,
    OP_SWAP  = 3'd6,
    OP_CLEAR = 3'd7
  } opcode_e;

  typedef enum logic [1:0] {
    ERR_NONE      = 2'd0,
    ERR_UNDERFLOW = 2'd1,
    ERR_OVERFLOW  = 2'd2
  } err_code_e;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_MUL  = 1'b1
  } state_e;

endpackage

// File: rtl/rpn_calc_core_if.sv
// Command/result bundle of the RPN calculator core; the core takes the slave side.
interface rpn_calc_core_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) ();
  logic                       cmd_valid;
  logic                       cmd_ready;
  logic [2:0]                 cmd_op;
  logic [WIDTH-1:0]           cmd_data;
  logic [WIDTH-1:0]           top;
  logic [WIDTH-1:0]           next;
  logic [$clog2(DEPTH+1)-1:0] count;
  logic                       err;
  logic [1:0]                 err_code;

  modport master (
    output cmd_valid, cmd_op, cmd_data,
    input  cmd_ready, top, next, count, err, err_code
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_data,
    output cmd_ready, top, next, count, err, err_code
  );
endinterface

// File: rtl/calc_seq_mult.sv
// Radix-2 shift-add multiplier, one multiplier bit per cycle, truncated to WIDTH bits.
module calc_seq_mult #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] product
);
  localparam int CNTW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] mcand, mplier, acc, step;
  logic [CNTW-1:0]  cnt;

  // The last partial product is added combinationally so the result is ready
  // on the same edge that done is sampled, WIDTH cycles after start.
  assign step    = acc + (mplier[0] ? mcand : '0);
  assign product = step;
  assign done    = busy && (cnt == CNTW'(1));

  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy   <= 1'b0;
      cnt    <= '0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
    end else if (start) begin
      busy   <= 1'b1;
      cnt    <= CNTW'(WIDTH);
      acc    <= '0;
      mcand  <= a;
      mplier <= b;
    end else if (busy) begin
      acc    <= step;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt - CNTW'(1);
      if (cnt == CNTW'(1)) busy <= 1'b0;
    end
  end
endmodule

// File: rtl/rpn_calc_core.sv
// Stack-based integer calculator: DEPTH x WIDTH operand stack driven by
// valid/ready commands; MUL runs on an iterative multiplier.
module rpn_calc_core
  import calc_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input logic            clk,
  input logic            rst,
  rpn_calc_core_if.slave bus
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef logic [CW-1:0] cnt_t;
  typedef logic [AW-1:0] idx_t;

  state_e           state;
  cnt_t             count;
  logic             err;
  err_code_e        err_code;
  logic [WIDTH-1:0] stack [DEPTH];

  idx_t             idx_top, idx_next, idx_push;
  logic             has1, has2, full, accept, mul_start;
  logic [WIDTH-1:0] top_v, next_v, product;
  logic             mul_busy, mul_done;
  opcode_e          op;

  logic             we_a, we_b, raise;
  idx_t             idx_a, idx_b;
  logic [WIDTH-1:0] data_a, data_b;
  err_code_e        raise_code;

  assign op        = opcode_e'(bus.cmd_op);
  assign idx_top   = idx_t'(count - cnt_t'(1));
  assign idx_next  = idx_t'(count - cnt_t'(2));
  assign idx_push  = idx_t'(count);
  assign has1      = (count != '0);
  assign has2      = (count >= cnt_t'(2));
  assign full      = (count == cnt_t'(DEPTH));
  assign top_v     = has1 ? stack[idx_top]  : '0;
  assign next_v    = has2 ? stack[idx_next] : '0;
  assign accept    = bus.cmd_valid && (state == S_IDLE);
  assign mul_start = accept && (op == OP_MUL) && has2;

  calc_seq_mult #(.WIDTH(WIDTH)) u_mult (
    .clk    (clk),
    .rst    (rst),
    .start  (mul_start),
    .a      (next_v),
    .b      (top_v),
    .busy   (mul_busy),
    .done   (mul_done),
    .product(product)
  );

  // NOTE: every signal assigned here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    we_a       = 1'b0;
    idx_a      = idx_top;
    data_a     = '0;
    we_b       = 1'b0;
    idx_b      = idx_next;
    data_b     = '0;
    raise      = 1'b0;
    raise_code = ERR_NONE;
    if (state == S_MUL) begin
      if (mul_done) begin
        we_a   = 1'b1;
        idx_a  = idx_next;
        data_a = product;
      end
    end else if (accept) begin
      unique case (op)
        OP_PUSH: begin
          if (full) begin
            raise      = 1'b1;
            raise_code = ERR_OVERFLOW;
          end else begin
            we_a   = 1'b1;
            idx_a  = idx_push;
            data_a = bus.cmd_data;
          end
        end
        OP_POP: begin
          if (!has1) begin
            raise      = 1'b1;
            raise_code = ERR_UNDERFLOW;
          end
        end
        OP_ADD, OP_SUB, OP_MUL, OP_SWAP: begin
          if (!has2) begin
            raise      = 1'b1;
            raise_code = ERR_UNDERFLOW;
          end else if (op == OP_ADD) begin
            we_a   = 1'b1;
            idx_a  = idx_next;
            data_a = next_v + top_v;
          end else if (op == OP_SUB) begin
            we_a   = 1'b1;
            idx_a  = idx_next;
            data_a = next_v - top_v;
          end else if (op == OP_SWAP) begin
            we_a   = 1'b1;
            data_a = next_v;
            we_b   = 1'b1;
            data_b = top_v;
          end
        end
        default: ;
      endcase
    end
  end

  // NOTE: the stack array has no reset; count alone marks entries valid, so
  // reset and CLEAR only need to zero the pointer.
  always_ff @(posedge clk) begin
    if (we_a) stack[idx_a] <= data_a;
    if (we_b) stack[idx_b] <= data_b;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      count    <= '0;
      err      <= 1'b0;
      err_code <= ERR_NONE;
    end else begin
      if (state == S_MUL) begin
        if (mul_done) begin
          count <= count - cnt_t'(1);
          state <= S_IDLE;
        end
      end else if (accept) begin
        unique case (op)
          OP_PUSH:        if (!full) count <= count + cnt_t'(1);
          OP_POP:         if (has1)  count <= count - cnt_t'(1);
          OP_ADD, OP_SUB: if (has2)  count <= count - cnt_t'(1);
          OP_MUL:         if (has2)  state <= S_MUL;
          OP_CLEAR: begin
            count    <= '0;
            err      <= 1'b0;
            err_code <= ERR_NONE;
          end
          default: ;
        endcase
      end
      // Only the first error since the last CLEAR is recorded.
      if (raise) begin
        err <= 1'b1;
        if (!err) err_code <= raise_code;
      end
    end
  end

  a_mul_busy: assert property (@(posedge clk) disable iff (rst)
                               (state == S_MUL) |-> mul_busy);

  assign bus.cmd_ready = (state == S_IDLE);
  assign bus.top       = top_v;
  assign bus.next      = next_v;
  assign bus.count     = count;
  assign bus.err       = err;
  assign bus.err_code  = err_code;
endmodule
